debounce_timer_arbiter: RTL and testbench
=========================================

Name: debounce_timer_arbiter

Overview:
- Shares one debounce interval timer between N debouncer FSM channels.
- Each channel requests the timer while its input is stable-pending and holds the request until it receives a done pulse.
- Grants the timer round-robin, counts TICKS cycles for the granted channel, then returns a one-cycle done pulse to that channel only.
- Sits between the per-button debouncer FSMs and the board clock. It replaces one free-running timer per button.

Parameters:
- N, 4, number of requesting channels (2..16).
- TICKS, 5, debounce interval in clk cycles per grant (>=2). Board builds use 1000000.
- CW, $clog2(TICKS), width of the internal interval counter.
- IW, $clog2(N), width of active_id.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  per-channel timer request, level. The requester holds it high until done.
- grant  output  N  one-hot, registered. The bit is high while that channel owns the timer.
- done  output  N  one-hot, one-cycle pulse: the interval has elapsed for the granted channel.
- busy  output  1  high whenever the state is not IDLE.
- active_id  output  IW  binary index of the granted channel. Holds its last value when idle.

Behaviour:
- Reset (async, any time, including mid-interval):
  - state=IDLE, grant=0, done=0, busy=0, active_id=0, counter=0.
  - Round-robin pointer = N-1, so channel 0 has first priority after reset.
- States: IDLE, RUN, DONE (Moore; all outputs are decoded from registers).
- IDLE:
  - If req!=0 at a rising edge: select the first requesting channel searching upward from pointer+1 with wrap (N-1 -> 0).
  - On that edge: state=RUN, grant bit set, active_id=index, counter=0.
  - If req==0: stay in IDLE.
- RUN:
  - Each edge with req[active_id]=1: counter increments.
  - When counter==TICKS-1 and req[active_id]=1: next state DONE.
  - Result: grant is high for exactly TICKS cycles in RUN.
- Abort:
  - If req[active_id]=0 at any RUN edge: state=IDLE, grant=0, counter=0, no done pulse, pointer=active_id.
  - Abort wins over completion on the same edge.
- DONE:
  - Exactly one cycle. done[active_id]=1 and grant is still high.
  - Next edge: state=IDLE, grant=0, pointer=active_id, regardless of req.
- Latency: req rising, sampled at edge E0 -> grant high from E0 -> done high in the cycle after edge E0+TICKS -> grant low after E0+TICKS+1.
- IDLE gap: at least one IDLE cycle between consecutive grants.
  - grant-to-grant period for back-to-back requesters is TICKS+2 cycles.
- Fairness:
  - After a grant ends (done or abort), the just-served channel has the lowest priority.
  - With all N requesting, each channel is served once per N grants.
- Non-granted request changes: requests from non-granted channels have no effect until IDLE.
- Reassertion: a channel that keeps req high after its done is re-arbitrated like any other channel.
- Output invariants:
  - grant and done are one-hot or zero.
  - done is never high for a channel without grant.
  - busy = (state!=IDLE).
- Counter: CW bits, never exceeds TICKS-1, cleared on every grant start.

Test Plan (N=4, TICKS=5):
- Reset then req=0001 held:
  - grant=0001 from E0 to E0+6.
  - done=0001 for exactly one cycle (after E0+5).
  - busy high 6 cycles, active_id=0.
- req=1111 held continuously:
  - grant order 0001, 0010, 0100, 1000, 0001.
  - Grant starts 7 cycles apart; one done pulse per grant.
- req=0100 granted, then req[2] dropped after 3 RUN cycles:
  - grant falls at that edge, done never pulses.
  - Next request 0110 is served as 0010? No: pointer=2, so channel 1 is served only after wrap. With req=0110, the grant goes to channel 1 (search 3,0,1).
- req[active] dropped on the edge where counter==4:
  - Abort taken, done stays 0, state=IDLE.
- Assert reset for 1 cycle mid-RUN (counter=2):
  - grant, done, busy and active_id go to 0 immediately (asynchronously).
  - After release with req=1000, grant=1000 and the full 5-cycle interval restarts.
- Grant held on channel 0 while req of channels 1-3 toggle every cycle:
  - Channel 0 interval unaffected, done=0001 after 5 RUN cycles.

Source files
------------

// File: rtl/debounce_timer_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : debounce_timer_arbiter_if
// Brief    : request/grant/done bundle between debouncer channels and the timer
// Revision : 1.0
// ---------------------------------------------------------------------------
interface debounce_timer_arbiter_if #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic          busy;
  logic [IW-1:0] active_id;

  modport master (output req, input grant, input done, input busy, input active_id);
  modport slave  (input req, output grant, output done, output busy, output active_id);
endinterface
`default_nettype wire

// File: rtl/debounce_timer_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : debounce_timer_arbiter
// Brief    : one shared debounce interval timer, granted round-robin to N channels
// Revision : 1.0
// ---------------------------------------------------------------------------
module debounce_timer_arbiter #(
  parameter int N     = 4,
  parameter int TICKS = 5,
  parameter int CW    = $clog2(TICKS),
  parameter int IW    = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  debounce_timer_arbiter_if.slave  bus
);

  localparam logic [1:0]    c_idle = 2'd0;
  localparam logic [1:0]    c_run  = 2'd1;
  localparam logic [1:0]    c_done = 2'd2;
  localparam logic [CW-1:0] c_last = CW'(TICKS - 1);
  localparam logic [N-1:0]  c_one  = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_active_id;
  logic [IW-1:0] r_ptr;
  logic [CW-1:0] r_count;

  logic          w_found;
  logic [IW-1:0] w_pick;
  logic          w_req_active;

  // First requester strictly after the pointer, wrapping N-1 -> 0.
  always_comb begin
    int            w_idx;
    logic [IW-1:0] w_cand;
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    w_cand  = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      w_cand = IW'(w_idx);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_req_active = bus.req[r_active_id];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_idle;
      r_grant     <= '0;
      r_active_id <= '0;
      r_ptr       <= IW'(N - 1);
      r_count     <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_found) begin
            r_state     <= c_run;
            r_grant     <= c_one << w_pick;
            r_active_id <= w_pick;
            r_count     <= '0;
          end
        end
        c_run: begin
          // A dropped request aborts even on the terminal count.
          if (!w_req_active) begin
            r_state <= c_idle;
            r_grant <= '0;
            r_count <= '0;
            r_ptr   <= r_active_id;
          end else if (r_count == c_last) begin
            r_state <= c_done;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        c_done: begin
          r_state <= c_idle;
          r_grant <= '0;
          r_count <= '0;
          r_ptr   <= r_active_id;
        end
        default: begin
          r_state <= c_idle;
          r_grant <= '0;
          r_count <= '0;
        end
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.done      = (r_state == c_done) ? r_grant : '0;
  assign bus.busy      = (r_state != c_idle);
  assign bus.active_id = r_active_id;

endmodule
`default_nettype wire

// File: tb/tb_debounce_timer_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_debounce_timer_arbiter
// Brief    : vector table, corner sequences and random traffic against a grant model
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_debounce_timer_arbiter;

  localparam int N     = 4;
  localparam int TICKS = 5;
  localparam int IW    = $clog2(N);

  logic clk;
  logic reset;

  debounce_timer_arbiter_if #(.N(N)) bus ();

  debounce_timer_arbiter #(.N(N), .TICKS(TICKS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;

  // Model: who owns the timer and how many cycles it has held it.
  int m_owner;
  int m_held;
  int m_last;
  int m_id;

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = N - 1;
    m_id    = 0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] r);
    bit found;
    int c;
    found = 0;
    if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (!found && r[c]) begin
          found   = 1;
          m_owner = c;
          m_id    = c;
          m_held  = 0;
        end
      end
    end else if (m_held < TICKS) begin
      if (!r[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else begin
      m_last  = m_owner;
      m_owner = -1;
    end
  endfunction

  function automatic logic [N-1:0] exp_grant();
    return (m_owner >= 0) ? N'(1 << m_owner) : '0;
  endfunction

  function automatic logic [N-1:0] exp_done();
    return (m_owner >= 0 && m_held == TICKS) ? N'(1 << m_owner) : '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_model(input string tag);
    check({tag, " grant"}, 32'(bus.grant), 32'(exp_grant()));
    check({tag, " done"},  32'(bus.done),  32'(exp_done()));
    check({tag, " busy"},  32'(bus.busy),  32'(m_owner >= 0));
    check({tag, " id"},    32'(bus.active_id), 32'(m_id));
  endtask

  task automatic apply(input logic [N-1:0] r);
    bus.req = r;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    reset   = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic          busy;
    logic [IW-1:0] id;
  } vec_t;

  vec_t vecs[10];

  logic [N-1:0] starts_g[8];
  int           starts_c[8];
  int           n_starts;
  int           n_done;
  int           done_at;
  logic [N-1:0] prev_grant;
  logic [N-1:0] rq;
  logic [N-1:0] pat;

  initial begin
    total   = 0;
    passed  = 0;
    reset   = 1'b1;
    bus.req = '0;
    model_reset();

    vecs[0] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vecs[1] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vecs[2] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vecs[3] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vecs[4] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vecs[5] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0};
    vecs[6] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[7] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vecs[8] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[9] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};

    #2;
    check("reset grant", 32'(bus.grant), 32'h0);
    check("reset done",  32'(bus.done),  32'h0);
    check("reset busy",  32'(bus.busy),  32'h0);
    check("reset id",    32'(bus.active_id), 32'h0);
    do_reset();

    // Single requester held: full interval, one done pulse, re-arbitrated.
    for (int v = 0; v < 10; v++) begin
      apply(vecs[v].req);
      check($sformatf("vec%0d grant", v), 32'(bus.grant), 32'(vecs[v].grant));
      check($sformatf("vec%0d done", v),  32'(bus.done),  32'(vecs[v].done));
      check($sformatf("vec%0d busy", v),  32'(bus.busy),  32'(vecs[v].busy));
      check($sformatf("vec%0d id", v),    32'(bus.active_id), 32'(vecs[v].id));
    end

    // All channels requesting: strict rotation, TICKS+2 spacing.
    do_reset();
    n_starts   = 0;
    n_done     = 0;
    prev_grant = '0;
    for (int c = 0; c < 30; c++) begin
      apply(4'b1111);
      if (bus.grant != 0 && prev_grant == 0 && n_starts < 8) begin
        starts_g[n_starts] = bus.grant;
        starts_c[n_starts] = c;
        n_starts++;
      end
      if (bus.done != 0) n_done++;
      prev_grant = bus.grant;
    end
    check("rr starts", 32'(n_starts), 32'd5);
    check("rr dones",  32'(n_done),   32'd4);
    check("rr g0", 32'(starts_g[0]), 32'b0001);
    check("rr g1", 32'(starts_g[1]), 32'b0010);
    check("rr g2", 32'(starts_g[2]), 32'b0100);
    check("rr g3", 32'(starts_g[3]), 32'b1000);
    check("rr g4", 32'(starts_g[4]), 32'b0001);
    for (int k = 1; k < 5; k++)
      check($sformatf("rr gap%0d", k), 32'(starts_c[k] - starts_c[k-1]), 32'd7);

    // Abort of channel 2, then pointer sits on 2 so channel 1 wins via wrap.
    do_reset();
    apply(4'b0100);
    check("abort grant on", 32'(bus.grant), 32'b0100);
    apply(4'b0100);
    apply(4'b0100);
    apply(4'b0000);
    check("abort grant", 32'(bus.grant), 32'h0);
    check("abort done",  32'(bus.done),  32'h0);
    check("abort busy",  32'(bus.busy),  32'h0);
    apply(4'b0110);
    check("after abort grant", 32'(bus.grant), 32'b0010);
    check("after abort id",    32'(bus.active_id), 32'd1);

    // Drop on the terminal count edge: abort wins.
    do_reset();
    for (int k = 0; k < 5; k++) apply(4'b0001);
    apply(4'b0000);
    check("late abort grant", 32'(bus.grant), 32'h0);
    check("late abort done",  32'(bus.done),  32'h0);
    check("late abort busy",  32'(bus.busy),  32'h0);
    apply(4'b0000);
    check("late abort quiet", 32'(bus.done), 32'h0);

    // Asynchronous reset mid-interval, then the interval restarts in full.
    do_reset();
    apply(4'b1000);
    apply(4'b1000);
    apply(4'b1000);
    check("pre-reset id", 32'(bus.active_id), 32'd3);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async grant", 32'(bus.grant), 32'h0);
    check("async done",  32'(bus.done),  32'h0);
    check("async busy",  32'(bus.busy),  32'h0);
    check("async id",    32'(bus.active_id), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    done_at = -1;
    for (int k = 0; k < 8; k++) begin
      apply(4'b1000);
      if (k == 0) check("restart grant", 32'(bus.grant), 32'b1000);
      if (bus.done != 0 && done_at < 0) begin
        done_at = k;
        check("restart done", 32'(bus.done), 32'b1000);
      end
    end
    check("restart done cycle", 32'(done_at), 32'd5);

    // Other channels toggling must not disturb the owner.
    do_reset();
    done_at = -1;
    for (int k = 0; k < 8; k++) begin
      pat = (k % 2 == 1) ? 4'b1111 : 4'b0001;
      apply(pat);
      if (k < 6) check($sformatf("hold grant%0d", k), 32'(bus.grant), 32'b0001);
      if (bus.done != 0 && done_at < 0) begin
        done_at = k;
        check("hold done", 32'(bus.done), 32'b0001);
      end
    end
    check("hold done cycle", 32'(done_at), 32'd5);

    // Random request traffic against the model.
    do_reset();
    rq = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < N; b++) begin
        if (rq[b]) begin
          if (bus.done[b] && $urandom_range(1, 0) == 1) rq[b] = 1'b0;
          else if ($urandom_range(15, 0) == 0) rq[b] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          rq[b] = 1'b1;
        end
      end
      apply(rq);
      compare_model($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
